// File: rtl/smart_lighting_ctrl_pkg.sv
// Shared types and defaults for the multi-zone occupancy lighting controller.
package smart_store_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON   = 2'd1,
        HOLD = 2'd2
    } zone_state_t;

    localparam int DEF_N_ZONES    = 4;
    localparam int DEF_TICK_DIV   = 1000;
    localparam int DEF_HOLD_TICKS = 30;
    localparam int DEF_DEB_CYCLES = 4;

    // Width needed to count 0..n occupied zones.
    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/smart_lighting_ctrl_if.sv
// Sensor/override/lamp bundle between the store panel side and the controller.
interface smart_lighting_ctrl_if import smart_store_pkg::*; #(
    parameter int N_ZONES = DEF_N_ZONES
);
    logic [N_ZONES-1:0]         pir;
    logic [N_ZONES-1:0]         force_on;
    logic                       force_off;
    logic [N_ZONES-1:0]         light;
    logic [occ_w(N_ZONES)-1:0]  occupied_cnt;

    modport master (output pir, force_on, force_off, input light, occupied_cnt);
    modport slave  (input pir, force_on, force_off, output light, occupied_cnt);
endinterface

// File: rtl/smart_lighting_ctrl_zone.sv
// One lighting zone: PIR synchroniser, debouncer, OFF/ON/HOLD FSM and hold timer.
module light_zone_fsm import smart_store_pkg::*; #(
    parameter int HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pir_i,
    input  logic        tick_i,
    input  logic        force_off_i,
    input  logic        dim_i,
    output zone_state_t state_o,
    output logic        light_pre_o
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          clean_q, clean_d;
    logic [DW-1:0] deb_q, deb_d;
    zone_state_t   state_q, state_d;
    logic [7:0]    tmr_q, tmr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            deb_q   <= '0;
            state_q <= OFF;
            tmr_q   <= '0;
        end else begin
            sync1_q <= pir_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            deb_q   <= deb_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_comb begin
        clean_d = clean_q;
        deb_d   = '0;
        if (sync2_q != clean_q) begin
            if (deb_q == DW'(DEB_CYCLES - 1)) clean_d = sync2_q;
            else                              deb_d   = deb_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (force_off_i) begin
            state_d = OFF;
            tmr_d   = '0;
        end else begin
            case (state_q)
                OFF: if (clean_q) state_d = ON;
                ON: begin
                    if (!clean_q) begin
                        if (HOLD_TICKS == 0) begin
                            state_d = OFF;
                        end else begin
                            state_d = HOLD;
                            tmr_d   = 8'(HOLD_TICKS);
                        end
                    end
                end
                HOLD: begin
                    // Re-occupation beats a coincident tick.
                    if (clean_q) begin
                        state_d = ON;
                        tmr_d   = '0;
                    end else if (tick_i) begin
                        if (tmr_q == 8'd1) begin
                            state_d = OFF;
                            tmr_d   = '0;
                        end else begin
                            tmr_d = tmr_q - 8'd1;
                        end
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Taken from next state so the lamp register lands with the FSM.
    assign light_pre_o = (state_d == ON) | ((state_d == HOLD) & dim_i);
    assign state_o     = state_q;

endmodule

// File: rtl/smart_lighting_ctrl.sv
// Multi-zone lighting controller top: shared prescaler, overrides, popcount.
// Optional LIGHT_DIM_EN: lamps in HOLD run at 25% PWM instead of solid on.
module smart_lighting_ctrl import smart_store_pkg::*; #(
    parameter int N_ZONES    = DEF_N_ZONES,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    smart_lighting_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = occ_w(N_ZONES);

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic               dim;
    logic [N_ZONES-1:0] light_pre;
    logic [N_ZONES-1:0] light_q, light_d;
    logic [CW-1:0]      occ_q, occ_d;
    zone_state_t        zstate [N_ZONES];

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

`ifdef LIGHT_DIM_EN
    logic [1:0] pwm_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_q <= '0;
        else       pwm_q <= pwm_q + 2'd1;
    end
    assign dim = (pwm_q == 2'd0);
`else
    assign dim = 1'b1;
`endif

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        light_zone_fsm #(
            .HOLD_TICKS (HOLD_TICKS),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_zone (
            .clk         (clk),
            .reset       (reset),
            .pir_i       (bus.pir[i]),
            .tick_i      (tick),
            .force_off_i (bus.force_off),
            .dim_i       (dim),
            .state_o     (zstate[i]),
            .light_pre_o (light_pre[i])
        );
    end

    assign light_d = bus.force_off ? '0 : (bus.force_on | light_pre);

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < N_ZONES; i++)
            if (zstate[i] != OFF) occ_d = occ_d + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            light_q <= '0;
            occ_q   <= '0;
        end else begin
            presc_q <= presc_d;
            light_q <= light_d;
            occ_q   <= occ_d;
        end
    end

    assign bus.light        = light_q;
    assign bus.occupied_cnt = occ_q;

endmodule

// File: tb/tb_smart_lighting_ctrl.sv
// Directed bench for smart_lighting_ctrl (TICK_DIV=10, HOLD_TICKS=3, DEB_CYCLES=4).
module tb_smart_lighting_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    smart_lighting_ctrl_if #(.N_ZONES(4)) bus ();

    smart_lighting_ctrl #(
        .N_ZONES    (4),
        .TICK_DIV   (10),
        .HOLD_TICKS (3),
        .DEB_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int early;
        int n;
        int gaps;
        int ones;

        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.pir       = '0;
        bus.force_on  = '0;
        bus.force_off = 1'b0;

        #12;
        check("reset_light", 32'(bus.light), 32'h0);
        check("reset_occ", 32'(bus.occupied_cnt), 32'h0);
        #10 reset = 1'b0;
        step(1);

        // 1: pir[0] rise reaches light in exactly 7 cycles, count one later
        bus.pir[0] = 1'b1;
        early = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (bus.light[0]) early++;
        end
        check("t1_no_early_light", 32'(early), 32'd0);
        step(1);
        check("t1_light_at_7", 32'(bus.light), 32'h1);
        check("t1_occ_still_0", 32'(bus.occupied_cnt), 32'd0);
        step(1);
        check("t1_occ_at_8", 32'(bus.occupied_cnt), 32'd1);

        // 2: 3-cycle glitch is filtered, 4-cycle pulse lights the zone
        bus.pir[1] = 1'b1;
        step(3);
        bus.pir[1] = 1'b0;
        early = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.light[1]) early++;
        end
        check("t2_glitch_filtered", 32'(early), 32'd0);
        bus.pir[1] = 1'b1;
        step(4);
        bus.pir[1] = 1'b0;
        step(2);
        check("t2_pulse_not_yet", 32'(bus.light[1]), 32'd0);
        step(1);
        check("t2_pulse_lit", 32'(bus.light[1]), 32'd1);
        step(45);
        check("t2_pulse_expired", 32'(bus.light), 32'h1);
        check("t2_occ", 32'(bus.occupied_cnt), 32'd1);

        // 3: hold-off of 3 ticks of 10 cycles after the debounced fall
        bus.pir[2] = 1'b1;
        step(7);
        check("t3_on", 32'(bus.light[2]), 32'd1);
        step(3);
        bus.pir[2] = 1'b0;
        n = 0;
        while (bus.light[2] && n < 60) begin
            step(1);
            n++;
        end
        check("t3_holdoff_window", 32'(n >= 28 && n <= 37), 32'd1);
        bus.pir[2] = 1'b1;
        step(8);
        bus.pir[2] = 1'b0;
        gaps = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) bus.pir[2] = 1'b1;
            step(1);
            if (!bus.light[2]) gaps++;
        end
        check("t3_retrigger_no_gap", 32'(gaps), 32'd0);

        // 4: global force_off beats everything, lights return on release
        bus.pir = 4'hF;
        step(10);
        check("t4_all_on", 32'(bus.light), 32'hF);
        check("t4_occ_4", 32'(bus.occupied_cnt), 32'd4);
        bus.force_off = 1'b1;
        step(1);
        check("t4_forced_dark", 32'(bus.light), 32'h0);
        step(1);
        check("t4_occ_cleared", 32'(bus.occupied_cnt), 32'd0);
        step(3);
        bus.force_off = 1'b0;
        step(1);
        check("t4_release_on", 32'(bus.light), 32'hF);
        step(1);
        check("t4_release_occ", 32'(bus.occupied_cnt), 32'd4);

        // 5: force_on lights an empty zone without touching the count
        bus.pir = 4'b0111;
        step(45);
        check("t5_zone3_off", 32'(bus.light), 32'h7);
        check("t5_occ_3", 32'(bus.occupied_cnt), 32'd3);
        bus.force_on = 4'b1000;
        step(1);
        check("t5_forced_on", 32'(bus.light), 32'hF);
        step(1);
        check("t5_occ_unchanged", 32'(bus.occupied_cnt), 32'd3);
        bus.force_on = '0;
        step(1);
        check("t5_force_dropped", 32'(bus.light), 32'h7);

        // 6: HOLD appearance, then async reset while zone 0 is holding
        bus.pir = 4'b0110;
        step(12);
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus.light[0]) ones++;
        end
`ifdef LIGHT_DIM_EN
        check("t6_hold_duty", 32'(ones), 32'd2);
`else
        check("t6_hold_solid", 32'(ones), 32'd8);
`endif
        #3 reset = 1'b1;
        #1;
        check("t6_async_light", 32'(bus.light), 32'h0);
        check("t6_async_occ", 32'(bus.occupied_cnt), 32'd0);
        bus.pir = '0;
        #2 reset = 1'b0;
        step(10);
        check("t6_after_reset_light", 32'(bus.light), 32'h0);
        check("t6_after_reset_occ", 32'(bus.occupied_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smart_lighting_ctrl.md
Name: smart_lighting_ctrl

Overview:
Multi-zone occupancy lighting controller, successor to the single-PIR light switch. Each zone's PIR input is synchronised and debounced, then drives an OFF/ON/HOLD state machine with a programmable hold-off timer. Global and per-zone manual overrides are provided, plus an occupied-zone count for the store status panel. All zones share one prescaler tick.

Parameters:
N_ZONES, 4, number of independent PIR/light channels (1..16)
TICK_DIV, 1000, clk cycles per hold-timer tick (>=2)
HOLD_TICKS, 30, ticks a light stays on after the PIR falls (0..255; 0 = immediate off)
DEB_CYCLES, 4, consecutive stable cycles required to accept a PIR change (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  reset, asynchronous, active-high
pir  in  N_ZONES  raw asynchronous PIR sensor inputs
force_on  in  N_ZONES  per-zone manual on (synchronous to clk)
force_off  in  1  global manual off, e.g. store closed (synchronous)
light  out  N_ZONES  registered lamp drive per zone
occupied_cnt  out  $clog2(N_ZONES+1)  number of zones in ON or HOLD

Behaviour:
- Reset: light=0, occupied_cnt=0, all FSMs OFF, timers/debounce/prescaler=0, sync flops=0. Asserting reset mid-operation clears everything immediately (async); operation resumes on the first clk edge after deassertion.
- Per zone: 2-flop synchroniser -> debouncer. The debouncer counts cycles where sync!=clean, clears on any match, and updates clean when the count reaches DEB_CYCLES. A glitch shorter than DEB_CYCLES cycles never reaches the FSM.
- Latency: a stable pir edge reaches light in exactly DEB_CYCLES+3 clk cycles (7 at default).
- Prescaler: free-running 0..TICK_DIV-1. tick is a 1-cycle pulse at wrap. The prescaler is shared and never restarted per zone.
- FSM per zone:
  - OFF: if clean=1, go to ON.
  - ON: if clean=0, go to HOLD and load timer=HOLD_TICKS. If HOLD_TICKS=0, go straight to OFF.
  - HOLD: if clean=1, go to ON (the timer is discarded). Else on tick: if timer==1, go to OFF; otherwise decrement the timer.
  - Hold duration is therefore in (HOLD_TICKS-1)*TICK_DIV .. HOLD_TICKS*TICK_DIV cycles.
- light = 1 in ON or HOLD, 0 in OFF, registered.
- Override priority: force_off > force_on > FSM.
  - force_off=1: all lights 0 on the next edge; FSMs forced to OFF; timers cleared.
  - On release of force_off: zones with clean=1 re-enter ON on the next edge.
  - force_on[i]=1: light[i]=1. The FSM keeps running underneath, and light follows the FSM once force_on drops.
- occupied_cnt: popcount of zones in ON/HOLD, registered, lagging the FSM state by 1 cycle. Overrides do not affect it; force_off reaches it via the forced OFF state.
- Simultaneous tick and clean rise in HOLD: the rise wins (go to ON).

Optional Feature:
LIGHT_DIM_EN. When defined, light[i] in HOLD becomes a 25% PWM: high when a free-running 2-bit counter ==0, so the lamp visibly dims before turning off. ON and force_on still give a solid 1. When undefined, HOLD gives a solid 1 and there is no PWM counter. occupied_cnt is unaffected either way.

Decomposition:
- Package smart_store_pkg: zone_state_t enum (OFF=2'd0, ON=2'd1, HOLD=2'd2), the default constants, and the width function for occupied_cnt.
- Sub-module light_zone_fsm, one per zone via generate: synchroniser, debouncer, FSM, hold timer. Inputs: tick, force_off. Outputs: zone state and light_pre.
- The top level holds the prescaler, override muxing, optional PWM and popcount.

Test Plan:
1. Defaults, pir[0] 0->1 held: light[0]=1 exactly 7 cycles later; occupied_cnt=1 one cycle after that; other zones stay 0.
2. pir[1] pulse of 3 cycles (DEB_CYCLES=4): light[1] stays 0 throughout. A 4-cycle pulse lights it.
3. TICK_DIV=10, HOLD_TICKS=3: pir[2] high then low: light[2] drops between 20 and 30 cycles after the debounced fall (+pipeline). Pir re-asserted during HOLD keeps light=1 with no gap.
4. All zones ON, force_off=1 for 5 cycles: all light=0 next edge and occupied_cnt=0. On release with pir still high, lights return 1 cycle later.
5. force_on[3]=1 with pir[3]=0: light[3]=1 and occupied_cnt unchanged. After force_on drops, light[3]=0 next edge.
6. Reset asserted mid-HOLD, asynchronously between edges: light drops immediately. After release with pir=0, light stays 0. With LIGHT_DIM_EN defined, HOLD shows a 1-in-4 duty pattern.
